// File: rtl/conv_stream_sequencer.sv
// rtl/conv_stream_sequencer.sv - x/f stream source and y stream sink with host load/read ports; optional CONV_SEQ_THROTTLE_EN
module conv_stream_sequencer #(
    parameter int LX = 128,
    parameter int LF = 32,
    parameter int WD = 8,
    parameter int WY = 21
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          ld_we,
    input  logic                          ld_sel,
    input  logic [$clog2(LX)-1:0]         ld_addr,
    input  logic [WD-1:0]                 ld_data,
    output logic [WD-1:0]                 m_data_out_x,
    output logic                          m_valid_x,
    input  logic                          m_ready_x,
    output logic [WD-1:0]                 m_data_out_f,
    output logic                          m_valid_f,
    input  logic                          m_ready_f,
    input  logic [WY-1:0]                 s_data_in_y,
    input  logic                          s_valid_y,
    output logic                          s_ready_y,
    input  logic [$clog2(LX-LF+1)-1:0]    rd_addr,
    output logic [WY-1:0]                 rd_data,
    output logic                          busy,
    output logic                          done
);
    localparam int LY  = LX - LF + 1;
    localparam int AXW = $clog2(LX);
    localparam int AFW = $clog2(LF);
    localparam int AYW = $clog2(LY);
    localparam int XCW = $clog2(LX + 1);
    localparam int FCW = $clog2(LF + 1);
    localparam int YCW = $clog2(LY + 1);
    localparam logic [XCW-1:0] X_END = XCW'(LX);
    localparam logic [FCW-1:0] F_END = FCW'(LF);
    localparam logic [YCW-1:0] Y_END = YCW'(LY);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [XCW-1:0] x_cnt_q, x_cnt_d;
    logic [FCW-1:0] f_cnt_q, f_cnt_d;
    logic [YCW-1:0] y_cnt_q, y_cnt_d;

    logic [WD-1:0]  xmem [LX];
    logic [WD-1:0]  fmem [LF];
    logic [WY-1:0]  ymem [LY];

    logic run, x_more, f_more, y_more;
    logic x_go, f_go, y_go;
    logic x_xfer, f_xfer, y_xfer;

    assign run    = (state_q == S_RUN);
    assign x_more = (x_cnt_q < X_END);
    assign f_more = (f_cnt_q < F_END);
    assign y_more = (y_cnt_q < Y_END);
    assign x_xfer = m_valid_x && m_ready_x;
    assign f_xfer = m_valid_f && m_ready_f;
    assign y_xfer = s_valid_y && s_ready_y;

`ifdef CONV_SEQ_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        x_hold_q, x_hold_d;
    logic        f_hold_q, f_hold_d;

    // LFSR advances only while running; hold flags keep an offered word valid until taken
    always_comb begin
        lfsr_d   = lfsr_q;
        x_hold_d = m_valid_x && !m_ready_x;
        f_hold_d = m_valid_f && !m_ready_f;
        if (run) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // throttle state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q   <= 16'hACE1;
            x_hold_q <= 1'b0;
            f_hold_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            x_hold_q <= x_hold_d;
            f_hold_q <= f_hold_d;
        end
    end

    assign x_go = lfsr_q[0] | x_hold_q;
    assign f_go = lfsr_q[1] | f_hold_q;
    assign y_go = lfsr_q[2];
`else
    assign x_go = 1'b1;
    assign f_go = 1'b1;
    assign y_go = 1'b1;
`endif

    // state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_cnt_q <= '0;
            f_cnt_q <= '0;
            y_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            x_cnt_q <= x_cnt_d;
            f_cnt_q <= f_cnt_d;
            y_cnt_q <= y_cnt_d;
        end
    end

    // counters clear on run entry and advance once per completed transfer
    always_comb begin
        x_cnt_d = x_cnt_q;
        f_cnt_d = f_cnt_q;
        y_cnt_d = y_cnt_q;
        if (!run && start) begin
            x_cnt_d = '0;
            f_cnt_d = '0;
            y_cnt_d = '0;
        end else if (run) begin
            if (x_xfer) x_cnt_d = x_cnt_q + 1'b1;
            if (f_xfer) f_cnt_d = f_cnt_q + 1'b1;
            if (y_xfer) y_cnt_d = y_cnt_q + 1'b1;
        end
    end

    // next state: leave RUN on the edge that completes the final transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (x_cnt_d == X_END && f_cnt_d == F_END && y_cnt_d == Y_END) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // stream handshakes and status derived from the current state
    always_comb begin
        busy         = run;
        done         = (state_q == S_DONE);
        m_valid_x    = run && x_more && x_go;
        m_valid_f    = run && f_more && f_go;
        s_ready_y    = run && y_more && y_go;
        m_data_out_x = xmem[x_cnt_q[AXW-1:0]];
        m_data_out_f = fmem[f_cnt_q[AFW-1:0]];
    end

    // host load port, only outside a run; out-of-range f addresses are dropped
    always_ff @(posedge clk) begin
        if (!run && ld_we) begin
            if (!ld_sel) begin
                xmem[ld_addr] <= ld_data;
            end else if (ld_addr < AXW'(LF)) begin
                fmem[ld_addr[AFW-1:0]] <= ld_data;
            end
        end
    end

    // capture y results; a reset cycle completes no handshake
    always_ff @(posedge clk) begin
        if (!reset && y_xfer) begin
            ymem[y_cnt_q[AYW-1:0]] <= s_data_in_y;
        end
    end

    assign rd_data = (rd_addr < AYW'(LY)) ? ymem[rd_addr] : '0;

endmodule

// File: tb/tb_conv_stream_sequencer.sv
// tb/tb_conv_stream_sequencer.sv - scoreboard bench for conv_stream_sequencer
module tb_conv_stream_sequencer;
    localparam int LX = 128;
    localparam int LF = 32;
    localparam int LY = LX - LF + 1;
    localparam int WD = 8;
    localparam int WY = 21;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ld_we;
    logic          ld_sel;
    logic [6:0]    ld_addr;
    logic [WD-1:0] ld_data;
    logic [WD-1:0] m_data_out_x;
    logic          m_valid_x;
    logic          m_ready_x;
    logic [WD-1:0] m_data_out_f;
    logic          m_valid_f;
    logic          m_ready_f;
    logic [WY-1:0] s_data_in_y;
    logic          s_valid_y;
    logic          s_ready_y;
    logic [6:0]    rd_addr;
    logic [WY-1:0] rd_data;
    logic          busy;
    logic          done;

    conv_stream_sequencer #(.LX(LX), .LF(LF), .WD(WD), .WY(WY)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .m_data_out_x(m_data_out_x), .m_valid_x(m_valid_x), .m_ready_x(m_ready_x),
        .m_data_out_f(m_data_out_f), .m_valid_f(m_valid_f), .m_ready_f(m_ready_f),
        .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int xm [LX];
    int fm [LF];
    int yg [LY];
    int xq [$];
    int fq [$];
    int ysent  = 0;
    int x_seen = 0;
    bit run_on = 0;
    bit mon_en = 1;
    bit fin_pend = 0;
    bit px_stall = 0, pf_stall = 0;
    logic [WD-1:0] px_data, pf_data;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else passed++;
    endtask

    // reference: y[n] = sum over taps of x[n+k]*f[k]
    task automatic build_golden();
        for (int n = 0; n < LY; n++) begin
            yg[n] = 0;
            for (int k = 0; k < LF; k++) yg[n] += xm[n + k] * fm[k];
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!mon_en || reset) begin
            px_stall = 0;
            pf_stall = 0;
        end else begin
            if (fin_pend) begin
                chk("done_state", {done, busy, m_valid_x, m_valid_f, s_ready_y}, 5'b10000);
                fin_pend = 0;
                run_on   = 0;
            end else if (run_on) begin
                chk("busy_in_run", {busy, done}, 2'b10);
                chk("x_valid", m_valid_x, xq.size() != 0);
                chk("f_valid", m_valid_f, fq.size() != 0);
                chk("y_ready", s_ready_y, ysent < LY);
                if (px_stall) chk("x_hold", m_data_out_x, px_data);
                if (pf_stall) chk("f_hold", m_data_out_f, pf_data);
                if (m_valid_x && m_ready_x) begin
                    if (xq.size() == 0) chk("x_extra", 1, 0);
                    else chk("x_data", $signed(m_data_out_x), xq.pop_front());
                    x_seen++;
                end
                if (m_valid_f && m_ready_f) begin
                    if (fq.size() == 0) chk("f_extra", 1, 0);
                    else chk("f_data", $signed(m_data_out_f), fq.pop_front());
                end
                if (s_valid_y && s_ready_y) ysent++;
                if (((m_valid_x && m_ready_x) || (m_valid_f && m_ready_f) || (s_valid_y && s_ready_y))
                    && xq.size() == 0 && fq.size() == 0 && ysent == LY)
                    fin_pend = 1;
            end
            px_stall = m_valid_x && !m_ready_x;
            pf_stall = m_valid_f && !m_ready_f;
            px_data  = m_data_out_x;
            pf_data  = m_data_out_f;
        end
    end

    task automatic load_all();
        @(posedge clk); #1;
        for (int i = 0; i < LX; i++) begin
            ld_we = 1; ld_sel = 0; ld_addr = 7'(i); ld_data = WD'(xm[i]);
            @(posedge clk); #1;
        end
        for (int i = 0; i < LF; i++) begin
            ld_we = 1; ld_sel = 1; ld_addr = 7'(i); ld_data = WD'(fm[i]);
            @(posedge clk); #1;
        end
        // f address beyond LF must be dropped, not aliased onto f[3]
        ld_we = 1; ld_sel = 1; ld_addr = 7'(LF + 3); ld_data = 8'h7F;
        @(posedge clk); #1;
        ld_we = 0;
        build_golden();
    endtask

    task automatic chk_ymem();
        for (int n = 0; n < LY; n++) begin
            rd_addr = 7'(n);
            #1;
            chk("ymem_rd", $signed(rd_data), yg[n]);
        end
    endtask

    // mode 0: full rate, 1: ready toggles 1010, 2: random
    task automatic do_run(input int mode, input bit junk, input int abort_at);
        int cyc;
        xq.delete();
        fq.delete();
        for (int i = 0; i < LX; i++) xq.push_back(xm[i]);
        for (int i = 0; i < LF; i++) fq.push_back(fm[i]);
        ysent = 0; x_seen = 0; fin_pend = 0;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        run_on = 1;
        cyc = 0;
        while (run_on && cyc < 4000) begin
            if (abort_at >= 0 && x_seen >= abort_at) begin
                mon_en = 0; ld_we = 0; reset = 1;
                @(posedge clk); #1;
                chk("abort_outputs", {busy, done, m_valid_x, m_valid_f, s_ready_y}, 5'b0);
                reset = 0; run_on = 0; fin_pend = 0; mon_en = 1;
                return;
            end
            case (mode)
                0: begin m_ready_x = 1; m_ready_f = 1; s_valid_y = 1; end
                1: begin m_ready_x = (cyc % 2 == 0); m_ready_f = (cyc % 2 == 0); s_valid_y = 1; end
                default: begin
                    m_ready_x = 1'($urandom_range(0, 1));
                    m_ready_f = 1'($urandom_range(0, 1));
                    s_valid_y = 1'($urandom_range(0, 1));
                end
            endcase
            s_data_in_y = (ysent < LY) ? WY'(yg[ysent]) : '0;
            if (junk && !fin_pend) begin
                ld_we = 1; ld_sel = 1'($urandom_range(0, 1));
                ld_addr = 7'($urandom_range(0, 127)); ld_data = 8'h7F;
            end else begin
                ld_we = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ld_we = 0;
        chk("run_finished", run_on, 0);
        run_on = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; start = 0; ld_we = 0; ld_sel = 0; ld_addr = 0; ld_data = 0;
        m_ready_x = 1; m_ready_f = 1; s_valid_y = 1; s_data_in_y = 0; rd_addr = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle", {busy, done, m_valid_x, m_valid_f, s_ready_y}, 5'b0);
        end

        for (int z = 0; z < LX; z++) xm[z] = z - 128;
        for (int z = 0; z < LF; z++) fm[z] = z - 64;
        load_all();
        do_run(0, 0, -1);
        chk_ymem();
        rd_addr = 7'd0;  #1 chk("golden_y0", $signed(rd_data), 177328);
        rd_addr = 7'd96; #1 chk("golden_y96", $signed(rd_data), 28336);

        do_run(2, 0, 50);
        do_run(2, 0, -1);
        chk_ymem();

        do_run(1, 1, -1);
        do_run(2, 0, -1);
        chk_ymem();

        for (int z = 0; z < LX; z++) xm[z] = int'($urandom_range(0, 255)) - 128;
        for (int z = 0; z < LF; z++) fm[z] = int'($urandom_range(0, 255)) - 128;
        load_all();
        do_run(2, 0, -1);
        chk_ymem();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
